// File: rtl/wash_timer.sv
// wash_timer: run timer feeding the washing-machine controller FSM.
// Numbers motor runs per job (0 = wash, 1 = rinse, 2 = spin), times each run
// with a clock prescaler and a per-run tick limit, and raises cycle_timeout_o
// or spin_timeout_o as a registered, held level.
// Optional valve watchdog: define WASH_TIMER_WDOG_EN to build it; otherwise
// valve_fault_o is tied low.
module wash_timer #(
  parameter int unsigned TICK_DIV        = 100,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned WASH_TICKS      = 600,
  parameter int unsigned RINSE_TICKS     = 300,
  parameter int unsigned SPIN_TICKS      = 200,
  parameter int unsigned VALVE_MAX_TICKS = 120
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       motor_on_i,
  input  logic       door_lock_i,
  input  logic       done_i,
  input  logic       fill_valve_on_i,
  input  logic       drain_valve_on_i,
  output logic       cycle_timeout_o,
  output logic       spin_timeout_o,
  output logic [1:0] run_idx_o,
  output logic       valve_fault_o
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] WASH_LIM   = CNT_W'(WASH_TICKS);
  localparam logic [CNT_W-1:0] RINSE_LIM  = CNT_W'(RINSE_TICKS);
  localparam logic [CNT_W-1:0] SPIN_LIM   = CNT_W'(SPIN_TICKS);
  localparam logic [1:0]       RUN_RINSE  = 2'd1;
  localparam logic [1:0]       RUN_SPIN   = 2'd2;
  localparam logic [1:0]       RUN_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       run_idx_q, run_idx_d;
  logic             cyc_q, cyc_d;
  logic             spin_q, spin_d;

  logic             abort_s;
  logic             start_s;
  logic             advance_s;
  logic             tick_s;
  logic             last_s;
  logic [CNT_W-1:0] limit_s;

  // Abort (door unlocked or end of job) overrides every other transition.
  assign abort_s   = !door_lock_i || done_i;
  // A new run may only begin while fewer than three runs have completed.
  assign start_s   = motor_on_i && (run_idx_q != RUN_DONE);
  // Timing advances only while the motor is on; a paused run resumes on the
  // same edge that sees motor_on return, so that edge also counts.
  assign advance_s = motor_on_i && ((state_q == ST_RUN) || (state_q == ST_PAUSE));
  assign tick_s    = (presc_q == PRESC_LAST);
  assign last_s    = advance_s && tick_s && ((cnt_q + CNT_ONE) == limit_s);

  // Select the tick limit of the current run.
  always_comb begin
    limit_s = SPIN_LIM;
    case (run_idx_q)
      2'd0:      limit_s = WASH_LIM;
      RUN_RINSE: limit_s = RINSE_LIM;
      default:   limit_s = SPIN_LIM;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the run FSM.
  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) state_d = ST_RUN;
          else         state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (!motor_on_i) state_d = ST_PAUSE;
          else if (last_s) state_d = ST_EXPIRED;
          else             state_d = ST_RUN;
        end
        ST_PAUSE: begin
          if (last_s)          state_d = ST_EXPIRED;
          else if (motor_on_i) state_d = ST_RUN;
          else                 state_d = ST_PAUSE;
        end
        ST_EXPIRED: begin
          if (!motor_on_i) state_d = ST_IDLE;
          else             state_d = ST_EXPIRED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of prescaler, tick counter, run number and timeout flags.
  always_comb begin
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    run_idx_d = run_idx_q;
    cyc_d     = cyc_q;
    spin_d    = spin_q;
    if (abort_s) begin
      presc_d   = '0;
      cnt_d     = '0;
      run_idx_d = 2'd0;
      cyc_d     = 1'b0;
      spin_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            presc_d = '0;
            cnt_d   = '0;
          end else begin
            presc_d = presc_q;
            cnt_d   = cnt_q;
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (advance_s) begin
            if (tick_s) begin
              presc_d = '0;
              cnt_d   = cnt_q + CNT_ONE;
              if (last_s) begin
                cyc_d  = (run_idx_q < RUN_SPIN);
                spin_d = (run_idx_q >= RUN_SPIN);
              end else begin
                cyc_d  = 1'b0;
                spin_d = 1'b0;
              end
            end else begin
              presc_d = presc_q + PRESC_ONE;
            end
          end else begin
            presc_d = presc_q;
            cnt_d   = cnt_q;
          end
        end
        ST_EXPIRED: begin
          if (!motor_on_i) begin
            cyc_d     = 1'b0;
            spin_d    = 1'b0;
            run_idx_d = (run_idx_q == RUN_DONE) ? RUN_DONE : (run_idx_q + 2'd1);
          end else begin
            cyc_d  = cyc_q;
            spin_d = spin_q;
          end
        end
        default: begin
          presc_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Run datapath and registered timeout outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      run_idx_q <= 2'd0;
      cyc_q     <= 1'b0;
      spin_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      run_idx_q <= run_idx_d;
      cyc_q     <= cyc_d;
      spin_q    <= spin_d;
    end
  end

  assign cycle_timeout_o = cyc_q;
  assign spin_timeout_o  = spin_q;
  assign run_idx_o       = run_idx_q;

`ifdef WASH_TIMER_WDOG_EN
  localparam logic [CNT_W-1:0] VALVE_LIM = CNT_W'(VALVE_MAX_TICKS);

  logic             wopen_q, wopen_d;
  logic [PW-1:0]    wpresc_q, wpresc_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             fault_q, fault_d;
  logic             valve_open_s;
  logic [PW-1:0]    wpresc_eff_s;
  logic [CNT_W-1:0] wcnt_eff_s;
  logic             wtick_s;

  // The edge that first sees a valve open already counts as prescaler step 0,
  // so the fault lands on the VALVE_MAX_TICKS*TICK_DIV-th open edge.
  assign valve_open_s = fill_valve_on_i || drain_valve_on_i;
  assign wpresc_eff_s = wopen_q ? wpresc_q : '0;
  assign wcnt_eff_s   = wopen_q ? wcnt_q : '0;
  assign wtick_s      = (wpresc_eff_s == PRESC_LAST);

  // Valve watchdog next-state: counts ticks while a valve is open.
  always_comb begin
    wopen_d  = wopen_q;
    wpresc_d = wpresc_q;
    wcnt_d   = wcnt_q;
    fault_d  = fault_q;
    if (abort_s) begin
      wopen_d  = 1'b0;
      wpresc_d = '0;
      wcnt_d   = '0;
      fault_d  = 1'b0;
    end else if (!valve_open_s) begin
      wopen_d  = 1'b0;
      wpresc_d = '0;
      wcnt_d   = '0;
    end else begin
      wopen_d = 1'b1;
      if (wtick_s) begin
        wpresc_d = '0;
        if ((wcnt_eff_s + CNT_ONE) >= VALVE_LIM) begin
          wcnt_d  = VALVE_LIM;
          fault_d = 1'b1;
        end else begin
          wcnt_d  = wcnt_eff_s + CNT_ONE;
        end
      end else begin
        wpresc_d = wpresc_eff_s + PRESC_ONE;
        wcnt_d   = wcnt_eff_s;
      end
    end
  end

  // Valve watchdog registers; the fault flag is sticky until abort or reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wopen_q  <= 1'b0;
      wpresc_q <= '0;
      wcnt_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      wopen_q  <= wopen_d;
      wpresc_q <= wpresc_d;
      wcnt_q   <= wcnt_d;
      fault_q  <= fault_d;
    end
  end

  assign valve_fault_o = fault_q;
`else
  logic unused_wdog_s;
  assign unused_wdog_s = ^{fill_valve_on_i, drain_valve_on_i, CNT_W'(VALVE_MAX_TICKS)};
  assign valve_fault_o = 1'b0;
`endif

endmodule
